// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall, taken-branch flush and registered EX operand-select generation.
// Define HAZARD_FWD_EN to forward from EX/MEM producers; otherwise dependents stall until write-through.
module hazard_fwd_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    logic       ex_valid;
    logic       ex_wen;
    logic [4:0] ex_dst;
    logic       mem_valid;
    logic       mem_wen;
    logic [4:0] mem_dst;
    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit_rs;
    logic       mem_hit_rt;

    function automatic logic match(input logic valid, input logic wen,
                                   input logic [4:0] dst, input logic [4:0] r);
        return valid & wen & (dst == r) & (r != 5'd0);
    endfunction

    // No WB entry is kept: the register file writes through, so a WB producer is already visible to ID.
    assign ex_hit_rs  = match(ex_valid, ex_wen, ex_dst, id_rs) & id_use_rs;
    assign ex_hit_rt  = match(ex_valid, ex_wen, ex_dst, id_rt) & id_use_rt;
    assign mem_hit_rs = match(mem_valid, mem_wen, mem_dst, id_rs) & id_use_rs;
    assign mem_hit_rt = match(mem_valid, mem_wen, mem_dst, id_rt) & id_use_rt;

    assign id_flush  = ex_branch_taken;
    assign ex_bubble = stall | ex_branch_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid  <= 1'b0;
            ex_wen    <= 1'b0;
            ex_dst    <= 5'd0;
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_dst   <= 5'd0;
        end else begin
            ex_valid  <= id_valid & ~ex_bubble;
            ex_wen    <= id_wen;
            ex_dst    <= id_dst;
            mem_valid <= ex_valid;
            mem_wen   <= ex_wen;
            mem_dst   <= ex_dst;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    logic       ex_is_load;
    logic [1:0] sel_a_next;
    logic [1:0] sel_b_next;
    logic [1:0] sel_a_q;
    logic [1:0] sel_b_q;

    // Only a load in EX cannot be forwarded in time; everything else is covered by the EX/MEM paths.
    assign stall = id_valid & ~ex_branch_taken & ex_is_load & (ex_hit_rs | ex_hit_rt);

    // The younger EX producer takes precedence over the older MEM one.
    always_comb begin
        sel_a_next = 2'b00;
        sel_b_next = 2'b00;
        if (!ex_bubble) begin
            if (ex_hit_rs)       sel_a_next = 2'b10;
            else if (mem_hit_rs) sel_a_next = 2'b01;
            if (ex_hit_rt)       sel_b_next = 2'b10;
            else if (mem_hit_rt) sel_b_next = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_is_load <= 1'b0;
            sel_a_q    <= 2'b00;
            sel_b_q    <= 2'b00;
        end else begin
            ex_is_load <= id_is_load & ~ex_bubble;
            sel_a_q    <= sel_a_next;
            sel_b_q    <= sel_b_next;
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;
`else
    logic unused_load;
    assign unused_load = id_is_load;

    // Without forwarding any in-flight EX/MEM producer of a source holds ID until the write-through.
    assign stall = id_valid & ~ex_branch_taken &
                   (ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt);

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: a driver pushes hand-computed per-cycle expectations, a monitor checks them.
// Expectations follow the HAZARD_FWD_EN setting the design is built with.
module tb_hazard_fwd_unit;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             resetn;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_dst;
    logic             id_wen;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             stall;
    logic             id_flush;
    logic             ex_bubble;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        logic             stall;
        logic             flush;
        logic             bubble;
        logic [1:0]       a;
        logic [1:0]       b;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_dst          (id_dst),
        .id_wen          (id_wen),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .id_flush        (id_flush),
        .ex_bubble       (ex_bubble),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    // One call = one cycle: ID inputs plus the outputs expected while they are presented.
    task automatic apply_stimulus(input logic rst, input logic v,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt,
                                  input logic [4:0] dst, input logic wen,
                                  input logic ld, input logic br,
                                  input logic e_stall, input logic [1:0] e_a,
                                  input logic [1:0] e_b, input int e_cnt);
        exp_t e;
        @(negedge clk);
        resetn          = rst;
        id_valid        = v;
        id_rs           = rs;
        id_rt           = rt;
        id_use_rs       = urs;
        id_use_rt       = urt;
        id_dst          = dst;
        id_wen          = wen;
        id_is_load      = ld;
        ex_branch_taken = br;
        e.stall  = e_stall;
        e.flush  = br;
        e.bubble = e_stall | br;
        e.a      = e_a;
        e.b      = e_b;
        e.cnt    = CNT_W'(e_cnt);
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] e_a, input logic [1:0] e_b, input int e_cnt);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_a, e_b, e_cnt);
    endtask

    task automatic check_output(input string name, input logic [CNT_W-1:0] act,
                                input logic [CNT_W-1:0] req);
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL vec %0d %s: actual %0h required %0h", vectors, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                check_output("stall",       CNT_W'(stall),     CNT_W'(e.stall));
                check_output("id_flush",    CNT_W'(id_flush),  CNT_W'(e.flush));
                check_output("ex_bubble",   CNT_W'(ex_bubble), CNT_W'(e.bubble));
                check_output("fwd_a_sel",   CNT_W'(fwd_a_sel), CNT_W'(e.a));
                check_output("fwd_b_sel",   CNT_W'(fwd_b_sel), CNT_W'(e.b));
                check_output("stall_count", stall_count,       e.cnt);
            end
        end
    end

    initial begin : driver
        resetn = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_dst = '0; id_wen = 1'b0; id_is_load = 1'b0; ex_branch_taken = 1'b0;

        //             rst v  rs rt urs urt dst wen ld br   stall a     b     cnt
        apply_stimulus(0,  0, 0, 0, 0,  0,  0,  0,  0, 0,   0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00, 0);
`ifdef HAZARD_FWD_EN
        // add $3,$1,$2 ; sub $4,$3,$5
        apply_stimulus(1,  1, 1, 2, 1,  1,  3,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 3, 5, 1,  1,  4,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        idle(2'b10, 2'b00, 0);
        // add $3 ; nop ; or $6,$3,$3
        apply_stimulus(1,  1, 1, 2, 1,  1,  3,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 0, 0, 0,  0,  0,  0,  0, 0,   0, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 3, 3, 1,  1,  6,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        idle(2'b01, 2'b01, 0);
        // lw $7 ; add $8,$7,$2 (one stall, then MEM forward)
        apply_stimulus(1,  1, 1, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 0,   1, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 0,   0, 2'b00, 2'b00, 1);
        idle(2'b01, 2'b00, 1);
        // lw $0 ; reader of $0
        apply_stimulus(1,  1, 1, 0, 1,  0,  0,  1,  1, 0,   0, 2'b00, 2'b00, 1);
        apply_stimulus(1,  1, 0, 0, 1,  1,  9,  1,  0, 0,   0, 2'b00, 2'b00, 1);
        idle(2'b00, 2'b00, 1);
        // lw $7 ; dependent reader killed by taken branch
        apply_stimulus(1,  1, 1, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 1);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 1,   0, 2'b00, 2'b00, 1);
        // add $3 ; lw $7,0($3) ; reset while the dependent add would stall
        apply_stimulus(1,  1, 1, 2, 1,  1,  3,  1,  0, 0,   0, 2'b00, 2'b00, 1);
        apply_stimulus(1,  1, 3, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 1);
        apply_stimulus(0,  1, 7, 2, 1,  1,  8,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00, 0);
        idle(2'b00, 2'b00, 0);
`else
        // add $3,$1,$2 ; add $4,$3,$5 (two stalls)
        apply_stimulus(1,  1, 1, 2, 1,  1,  3,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 3, 5, 1,  1,  4,  1,  0, 0,   1, 2'b00, 2'b00, 0);
        apply_stimulus(1,  1, 3, 5, 1,  1,  4,  1,  0, 0,   1, 2'b00, 2'b00, 1);
        apply_stimulus(1,  1, 3, 5, 1,  1,  4,  1,  0, 0,   0, 2'b00, 2'b00, 2);
        idle(2'b00, 2'b00, 2);
        // add $3 ; nop ; or $6,$3,$3 (one stall on MEM match)
        apply_stimulus(1,  1, 1, 2, 1,  1,  3,  1,  0, 0,   0, 2'b00, 2'b00, 2);
        apply_stimulus(1,  1, 0, 0, 0,  0,  0,  0,  0, 0,   0, 2'b00, 2'b00, 2);
        apply_stimulus(1,  1, 3, 3, 1,  1,  6,  1,  0, 0,   1, 2'b00, 2'b00, 2);
        apply_stimulus(1,  1, 3, 3, 1,  1,  6,  1,  0, 0,   0, 2'b00, 2'b00, 3);
        idle(2'b00, 2'b00, 3);
        // lw $7 ; add $8,$7,$2 (two stalls)
        apply_stimulus(1,  1, 1, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 3);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 0,   1, 2'b00, 2'b00, 3);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 0,   1, 2'b00, 2'b00, 4);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 0,   0, 2'b00, 2'b00, 5);
        // lw $0 ; reader of $0
        apply_stimulus(1,  1, 1, 0, 1,  0,  0,  1,  1, 0,   0, 2'b00, 2'b00, 5);
        apply_stimulus(1,  1, 0, 0, 1,  1,  9,  1,  0, 0,   0, 2'b00, 2'b00, 5);
        idle(2'b00, 2'b00, 5);
        // lw $7 ; dependent reader killed by taken branch
        apply_stimulus(1,  1, 1, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 5);
        apply_stimulus(1,  1, 7, 2, 1,  1,  8,  1,  0, 1,   0, 2'b00, 2'b00, 5);
        idle(2'b00, 2'b00, 5);
        // lw $7 ; reset while the dependent add would stall
        apply_stimulus(1,  1, 1, 0, 1,  0,  7,  1,  1, 0,   0, 2'b00, 2'b00, 5);
        apply_stimulus(0,  1, 7, 2, 1,  1,  8,  1,  0, 0,   0, 2'b00, 2'b00, 0);
        idle(2'b00, 2'b00, 0);
        idle(2'b00, 2'b00, 0);
`endif
        @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline hazard controller for the 5-stage CPU. Tracks destination registers of instructions in EX, MEM and WB and generates the registered 2-bit forwarding selects for the EX-stage operand `mux3` instances (00 = register file, 01 = WB result, 10 = MEM result). Also generates the load-use stall, the taken-branch flush and a stall-cycle counter. Sits beside the ID/EX pipeline register and is its sole source of operand-select codes.

## Interface
Parameters:
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  5 each  ID source register numbers.
- `id_use_rs`, `id_use_rt`  in  1 each  source actually read.
- `id_dst`  in  5  ID destination register.
- `id_wen`  in  1  ID instruction writes `id_dst`.
- `id_is_load`  in  1  ID instruction is a load.
- `ex_branch_taken`  in  1  branch in EX resolved taken this cycle.
- `stall`  out  1  hold PC and IF/ID this cycle (combinational).
- `id_flush`  out  1  replace IF/ID content with bubble (combinational, = `ex_branch_taken`).
- `ex_bubble`  out  1  load bubble into ID/EX at next edge (combinational, = `stall | ex_branch_taken`).
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  registered select codes for the EX rs/rt operand muxes.
- `stall_count`  out  CNT_W  cycles in which `stall` was 1.

## Operation
- Internal tracking entries `ex_*`, `mem_*`, `wb_*`: valid, dst[4:0], wen, is_load. Each edge: `wb <= mem`, `mem <= ex`; `ex <= id` fields, or bubble (valid=0) when `ex_bubble`.
- Match(S, r): `S.valid & S.wen & S.dst == r & r != 0`. Register 0 never matches.
- Load-use: `stall = id_valid & ~ex_branch_taken & ex.is_load & (Match(ex,id_rs)&id_use_rs | Match(ex,id_rt)&id_use_rt)`.
- Select per source r (computed in ID, registered into EX): Match(ex,r) -> 10; else Match(mem,r) -> 01; else 00. The register file is write-through during WB, so a WB-stage match needs no forwarding. Younger producer (ex) wins over older (mem).
- Selects register to 00 when `ex_bubble` is 1 or the source is unused.
- Branch flush has priority over stall: taken branch in EX kills the ID instruction, so no stall is raised for it.
- `stall_count` increments by 1 on each edge with `stall`=1; wraps modulo 2^CNT_W.

## Timing
- Reset (async, `resetn`=0): all tracking valid=0, `fwd_a_sel`=`fwd_b_sel`=00, `stall_count`=0; hence `stall`=0, `ex_bubble`=0 (given `ex_branch_taken`=0).
- Forwarding latency: select is valid in the cycle the consumer is in EX, one edge after it was computed in ID.
- Load-use: exactly one stall cycle with forwarding; after the stall the load is in MEM relative to the ID consumer, so select resolves to 01.
- Mid-operation reset clears all entries immediately; no stall or select survives.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- Not defined: selects are constant 00; `stall` asserted whenever an ID source matches ex or mem (any instruction type, not only loads), branch priority unchanged; a dependent instruction stalls up to 2 cycles and reads the value through the write-through register file.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` -> sub in EX with `fwd_a_sel`=10, `fwd_b_sel`=00, `stall` never 1.
- `add $3,..`, `nop`, `or $6,$3,$3` -> or in EX with both selects 01.
- `lw $7,0($1)` then `add $8,$7,$2` -> `stall`=1 for exactly one cycle, `ex_bubble`=1, then `fwd_a_sel`=01; `stall_count`=1.
- Writer with `id_dst`=0 followed by reader of $0 -> selects 00, no stall.
- `lw $7` then dependent reader while `ex_branch_taken`=1 -> `stall`=0, `id_flush`=1, `stall_count` unchanged.
- Assert `resetn`=0 during a load-use stall -> `stall`, selects and `stall_count` go to 0 immediately; without `HAZARD_FWD_EN`, back-to-back dependent add stalls 2 cycles with selects 00.
